uart_word_tx: RTL and testbench

Transmit side of the host UART link. Accepts one wide result word (e.g. the INFERENCE register contents after a read command) through a valid/ready handshake, then serializes it as consecutive 8N1 UART frames on the board's TX line, least-significant byte first. Sits between the control unit's readback path and `uart_txd` in `top_level`. Mirrors the receiver's bit timing, so a host that writes to the CPU can read results back.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_baud_gen.sv | 25 ++
 rtl/uart_word_tx.sv | 125 ++++++++++++
 tb/tb_uart_word_tx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the TX and RX sides of the host link.
package uart_pkg;
  localparam int UART_DATA_BITS = 8;
  localparam int UART_STOP_BITS = 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;
endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period tick generator; restart_in realigns the period to the current edge.
module uart_baud_gen #(
  parameter int BAUD_DIV = 25
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic restart_in,
  output logic tick_out
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || restart_in) cnt_q <= '0;
    else                      cnt_q <= cnt_d;
  end

  assign tick_out = (cnt_q == LAST);
endmodule

// File: rtl/uart_word_tx.sv
// Serializes one WORD_WIDTH word as back-to-back 8N1 frames, LSB byte first.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = 25,
  parameter int WORD_WIDTH = 64
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  word_valid_in,
  output logic                  word_ready_out,
  output logic                  tx_out,
  output logic                  busy_out,
  output logic                  done_out
);
  localparam int NBYTES = WORD_WIDTH / 8;
  localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);
  localparam logic [2:0]     LAST_BIT  = 3'(UART_DATA_BITS - 1);

  tx_state_t             state_q;
  logic [WORD_WIDTH-1:0] shift_q;
  logic [BCW-1:0]        byte_q;
  logic [2:0]            bit_q, bit_d;
  logic                  tx_q, ready_q, busy_q, done_q;
  logic                  tick, handshake;

  assign handshake = word_valid_in && ready_q && (state_q == IDLE);
  assign bit_d     = bit_q + 3'd1;

  uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .restart_in(handshake),
    .tick_out  (tick)
  );

`ifdef UART_TX_PARITY_EN
  logic par_bit;
  assign par_bit = ^shift_q[7:0];
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      shift_q <= '0;
      byte_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          tx_q    <= 1'b1;
          if (handshake) begin
            shift_q <= word_in;
            byte_q  <= '0;
            state_q <= START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        START: if (tick) begin
          state_q <= DATA;
          bit_q   <= '0;
          tx_q    <= shift_q[0];
        end
        DATA: if (tick) begin
          if (bit_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_q <= PARITY;
            tx_q    <= par_bit;
`else
            state_q <= STOP;
            tx_q    <= 1'b1;
`endif
          end else begin
            bit_q <= bit_d;
            tx_q  <= shift_q[bit_d];
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (tick) begin
          state_q <= STOP;
          tx_q    <= 1'b1;
        end
`endif
        STOP: if (tick) begin
          // Last byte returns to IDLE; otherwise the next start bit follows immediately.
          if (byte_q == LAST_BYTE) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            tx_q    <= 1'b1;
          end else begin
            shift_q <= shift_q >> UART_DATA_BITS;
            byte_q  <= byte_q + BCW'(1);
            state_q <= START;
            tx_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign word_ready_out = ready_q;
  assign tx_out         = tx_q;
  assign busy_out       = busy_q;
  assign done_out       = done_q;
endmodule

// File: tb/tb_uart_word_tx.sv
// Self-checking bench for uart_word_tx; line waveform compared against a frame model.
module tb_uart_word_tx;
  localparam int BD = 25;
  localparam int WW = 16;
  localparam int NB = WW / 8;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FL = FB * BD;
  localparam int F  = NB * FL;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [WW-1:0] word = '0;
  logic          valid = 1'b0;
  logic          ready, tx, busy, done;

  int total = 0;
  int bad   = 0;

  uart_word_tx #(.BAUD_DIV(BD), .WORD_WIDTH(WW)) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .word_in       (word),
    .word_valid_in (valid),
    .word_ready_out(ready),
    .tx_out        (tx),
    .busy_out      (busy),
    .done_out      (done)
  );

  always #5 clk = ~clk;

  // Expected line level c cycles after the start bit began.
  function automatic logic exp_tx(input logic [WW-1:0] w, input int c);
    int fr, b;
    logic [7:0] by;
    fr = c / FL;
    b  = (c % FL) / BD;
    by = 8'(w >> (8 * fr));
    if (b == 0) return 1'b0;
    if (b <= 8) return by[b-1];
    if (FB == 11 && b == 9) return ^by;
    return 1'b1;
  endfunction

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Called at a negedge with valid/word already set; records deviations from the model.
  task automatic capture(input logic [WW-1:0] w, input int sw_c, input bit sw_valid,
                         input logic [WW-1:0] sw_word,
                         output int line_bad, output int done_bad, output int stat_bad);
    line_bad = 0; done_bad = 0; stat_bad = 0;
    @(posedge clk);
    for (int c = 0; c <= F; c++) begin
      @(negedge clk);
      if (c == 0) valid = 1'b0;
      if (c == sw_c) begin
        valid = sw_valid;
        word  = sw_word;
      end
      if (c < F) begin
        if (tx !== exp_tx(w, c)) line_bad++;
        if (done !== 1'b0) done_bad++;
        if (busy !== 1'b1 || ready !== 1'b0) stat_bad++;
      end else begin
        if (tx !== 1'b1) line_bad++;
        if (done !== 1'b1) done_bad++;
        if (busy !== 1'b0 || ready !== 1'b1) stat_bad++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (tx !== 1'b1 || ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold: tx=%b ready=%b busy=%b done=%b expected 1 0 0 0", tx, ready, busy, done);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: tx=%b ready=%b busy=%b done=%b expected 1 1 0 0", tx, ready, busy, done);
    end
  endtask

  task automatic test_single(input logic [WW-1:0] w, input string nm);
    bit ok;
    int lb, db, sb;
    wait_ready(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_ready: ready never rose, expected 1", nm);
      return;
    end
    word = w; valid = 1'b1;
    capture(w, -1, 1'b0, '0, lb, db, sb);
    total += 3;
    if (lb !== 0) begin bad++; $display("FAIL %s_line: word %h bad cycles=%0d expected 0", nm, w, lb); end
    if (db !== 0) begin bad++; $display("FAIL %s_done: done errors=%0d expected 0 (pulse at %0d)", nm, db, F); end
    if (sb !== 0) begin bad++; $display("FAIL %s_status: busy/ready errors=%0d expected 0", nm, sb); end
  endtask

  task automatic test_pair(input logic [WW-1:0] w0, input logic [WW-1:0] w1, input int sw_c,
                           input string nm);
    bit ok;
    int lb, db, sb;
    wait_ready(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_ready: ready never rose, expected 1", nm);
      return;
    end
    word = w0; valid = 1'b1;
    capture(w0, sw_c, 1'b1, w1, lb, db, sb);
    total += 2;
    if (lb !== 0) begin bad++; $display("FAIL %s_first_line: word %h bad cycles=%0d expected 0", nm, w0, lb); end
    if (db + sb !== 0) begin bad++; $display("FAIL %s_first_ctl: done/status errors=%0d expected 0", nm, db + sb); end
    capture(w1, -1, 1'b0, '0, lb, db, sb);
    total += 2;
    if (lb !== 0) begin bad++; $display("FAIL %s_second_line: word %h bad cycles=%0d expected 0", nm, w1, lb); end
    if (db + sb !== 0) begin bad++; $display("FAIL %s_second_ctl: done/status errors=%0d expected 0", nm, db + sb); end
  endtask

  task automatic test_ignore_busy();
    test_pair(16'h3C96, 16'hFFFF, 100, "ignore_busy");
  endtask

  task automatic test_back_to_back();
    test_pair(16'h0001, 16'h8000, 0, "back_to_back");
  endtask

  task automatic test_random();
    for (int k = 0; k < 5; k++) begin
      logic [WW-1:0] a, b;
      a = WW'($urandom);
      b = WW'($urandom);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      if ($urandom_range(0, 1) == 1) test_pair(a, b, $urandom_range(0, F - 1), "rand_pair");
      else                           test_single(a, "rand_single");
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int errs;
    wait_ready(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL reset_mid_ready: ready never rose, expected 1");
      return;
    end
    word = WW'($urandom); valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    repeat (60) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (tx !== 1'b1 || busy !== 1'b0 || ready !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_abort: tx=%b busy=%b ready=%b done=%b expected 1 0 0 0", tx, busy, ready, done);
    end
    rst = 1'b0;
    errs = 0;
    for (int i = 0; i < 2 * F; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || done !== 1'b0 || busy !== 1'b0) errs++;
    end
    total += 2;
    if (errs !== 0) begin bad++; $display("FAIL reset_mid_quiet: line activity cycles=%0d expected 0", errs); end
    if (ready !== 1'b1) begin bad++; $display("FAIL reset_mid_ready_after: ready=%b expected 1", ready); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    test_single(16'h0703, "parity");
  endtask
`endif

  initial begin
    test_reset();
    test_single(16'hA55A, "single");
    test_ignore_busy();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
